// File: rtl/serial_cmd_decoder.sv
// serial_cmd_decoder
// Assembles 11-byte command frames from a UART byte stream:
//   A5, opcode, addr[7:0..31:24], data[7:0..31:24], checksum
// The checksum is the XOR of opcode through data[31:24]. A decoded command is
// presented with a valid/ready handshake and held stable until it is accepted.
// Rejected frames, inter-byte timeouts and bytes arriving while a command is
// held all bump a saturating error counter.

module serial_cmd_decoder #(
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic        clk,
   input  logic        i_rst,
   input  logic [7:0]  i_data,
   input  logic        i_en,
   output logic        o_cmd_valid,
   input  logic        i_cmd_ready,
   output logic [7:0]  o_cmd_op,
   output logic [31:0] o_cmd_addr,
   output logic [31:0] o_cmd_data,
   output logic [7:0]  o_err_cnt,
   output logic        o_busy
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_OP   = 3'd1;
   localparam logic [2:0] ST_ADDR = 3'd2;
   localparam logic [2:0] ST_DATA = 3'd3;
   localparam logic [2:0] ST_CSUM = 3'd4;
   localparam logic [2:0] ST_HOLD = 3'd5;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // The gap counter only needs to reach TIMEOUT_CYCLES-1; the next idle
   // cycle after that is the timeout itself.
   localparam int GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

   logic [2:0]       state_q,    state_d;
   logic [1:0]       idx_q,      idx_d;
   logic [7:0]       csum_q,     csum_d;
   logic [GAP_W-1:0] gap_q,      gap_d;
   logic [7:0]       op_q,       op_d;
   logic [31:0]      addr_q,     addr_d;
   logic [31:0]      data_q,     data_d;
   logic [7:0]       out_op_q,   out_op_d;
   logic [31:0]      out_addr_q, out_addr_d;
   logic [31:0]      out_data_q, out_data_d;
   logic [7:0]       err_q,      err_d;
   logic             err_inc;

   // Next-state logic: frame parsing, inter-byte timeout and error counting.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d    = state_q;
      idx_d      = idx_q;
      csum_d     = csum_q;
      gap_d      = gap_q;
      op_d       = op_q;
      addr_d     = addr_q;
      data_d     = data_q;
      out_op_d   = out_op_q;
      out_addr_d = out_addr_q;
      out_data_d = out_data_q;
      err_inc    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Anything other than the sync byte is line noise, not an error.
            if (i_en && i_data == SYNC_BYTE) begin
               state_d = ST_OP;
            end
         end
         ST_OP: begin
            if (i_en) begin
               op_d    = i_data;
               csum_d  = i_data;
               idx_d   = 2'd0;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (i_en) begin
               addr_d[8*idx_q +: 8] = i_data;
               csum_d               = csum_q ^ i_data;
               idx_d                = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (i_en) begin
               data_d[8*idx_q +: 8] = i_data;
               csum_d               = csum_q ^ i_data;
               idx_d                = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d = ST_CSUM;
               end
            end
         end
         ST_CSUM: begin
            if (i_en) begin
               if (i_data == csum_q) begin
                  // Outputs change only here, so the consumer never sees a partial frame.
                  state_d    = ST_HOLD;
                  out_op_d   = op_q;
                  out_addr_d = addr_q;
                  out_data_d = data_q;
               end else begin
                  state_d = ST_IDLE;
                  err_inc = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            // A byte here is dropped even on the accepting cycle; it is never
            // reinterpreted as the sync of a new frame.
            if (i_en) begin
               err_inc = 1'b1;
            end
            if (i_cmd_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // The gap timer runs only while a frame is partially received.
      if (state_q inside {ST_OP, ST_ADDR, ST_DATA, ST_CSUM}) begin
         if (i_en) begin
            gap_d = '0;
         end else if (gap_q == GAP_LAST) begin
            state_d = ST_IDLE;
            gap_d   = '0;
            err_inc = 1'b1;
         end else begin
            gap_d = gap_q + 1'b1;
         end
      end

      err_d = err_q;
      if (err_inc && err_q != 8'hFF) begin
         err_d = err_q + 8'd1;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (i_rst) begin
         // NOTE: the datapath registers are reset too, because the command outputs must read zero after reset.
         state_q    <= ST_IDLE;
         idx_q      <= 2'd0;
         csum_q     <= 8'd0;
         gap_q      <= '0;
         op_q       <= 8'd0;
         addr_q     <= 32'd0;
         data_q     <= 32'd0;
         out_op_q   <= 8'd0;
         out_addr_q <= 32'd0;
         out_data_q <= 32'd0;
         err_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         csum_q     <= csum_d;
         gap_q      <= gap_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         out_op_q   <= out_op_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
         err_q      <= err_d;
      end
   end

   assign o_cmd_valid = (state_q == ST_HOLD);
   assign o_busy      = (state_q != ST_IDLE);
   assign o_cmd_op    = out_op_q;
   assign o_cmd_addr  = out_addr_q;
   assign o_cmd_data  = out_data_q;
   assign o_err_cnt   = err_q;

endmodule

// File: doc/serial_cmd_decoder.md
SERIAL_CMD_DECODER -- requirements
Module: serial_cmd_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 20000, max clk cycles allowed between consecutive bytes inside one frame.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port i_data  input  8  received byte from the UART deserializer.
REQ-005 SHALL have port i_en  input  1  one-cycle strobe marking i_data valid.
REQ-006 SHALL have port o_cmd_valid  output  1  decoded command available.
REQ-007 SHALL have port i_cmd_ready  input  1  consumer accepts command.
REQ-008 SHALL have port o_cmd_op  output  8  opcode byte.
REQ-009 SHALL have port o_cmd_addr  output  32  address.
REQ-010 SHALL have port o_cmd_data  output  32  write data.
REQ-011 SHALL have port o_err_cnt  output  8  saturating count of rejected frames and dropped bytes.
REQ-012 SHALL have port o_busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Frame format SHALL be 11 bytes: sync 0xA5, opcode, addr[7:0]..addr[31:24], data[7:0]..data[31:24], checksum; multi-byte fields LSB first.
REQ-014 Checksum SHALL equal XOR of the 9 bytes opcode through data[31:24]; sync byte excluded.
REQ-015 States SHALL be IDLE, OP, ADDR, DATA, CSUM, HOLD; a 2-bit byte index counts within ADDR and DATA.
REQ-016 IDLE: i_en with i_data==0xA5 -> OP; any other byte ignored, no error count.
REQ-017 OP: i_en latches opcode, seeds running checksum, -> ADDR with index 0.
REQ-018 ADDR/DATA: each i_en stores byte at lane [8*index+7:8*index], XORs into checksum; after index 3 advance (ADDR->DATA, DATA->CSUM), index wraps to 0.
REQ-019 CSUM: i_en with match -> HOLD, o_cmd_valid asserted the next cycle (one clk after the final byte strobe); mismatch -> IDLE, o_err_cnt +1.
REQ-020 HOLD: o_cmd_valid, o_cmd_op, o_cmd_addr, o_cmd_data SHALL stay stable until cycle where o_cmd_valid & i_cmd_ready; then -> IDLE, o_cmd_valid low next cycle.
REQ-021 i_cmd_ready while o_cmd_valid low SHALL have no effect.
REQ-022 Byte arriving in HOLD SHALL be dropped and o_err_cnt +1; if it coincides with the accepting handshake, it SHALL still be dropped (not parsed as sync).
REQ-023 Gap counter SHALL clear on every i_en and increment each cycle in OP, ADDR, DATA, CSUM; reaching TIMEOUT_CYCLES -> IDLE, o_err_cnt +1, partial frame discarded; counter inactive in IDLE and HOLD.
REQ-024 0xA5 received mid-frame SHALL be treated as ordinary payload, not resync.
REQ-025 o_err_cnt SHALL saturate at 255 and never wrap.
REQ-026 Output fields SHALL update only on entry to HOLD; in other states they hold last accepted values.

Reset
REQ-027 On i_rst: state IDLE, o_cmd_valid 0, o_cmd_op 0, o_cmd_addr 0, o_cmd_data 0, o_err_cnt 0, o_busy 0, gap counter 0, byte index 0, checksum 0.
REQ-028 i_rst asserted mid-frame or in HOLD SHALL abandon the frame/command with no error count; i_en in the reset cycle ignored.
REQ-029 First frame after reset release SHALL decode normally with no warm-up cycles.

Verification
REQ-030 Bytes A5 01 78 56 34 12 EF BE AD DE chk(=XOR of 01..DE) with i_cmd_ready=1 -> one cycle o_cmd_valid with op 0x01, addr 0x12345678, data 0xDEADBEEF; o_err_cnt 0.
REQ-031 Same frame with checksum bit 0 flipped -> no o_cmd_valid, o_err_cnt 1, o_busy 0; following valid frame decodes.
REQ-032 Valid frame, i_cmd_ready=0 for 50 cycles then 1 -> outputs stable throughout; two extra bytes sent during hold -> o_err_cnt 2, accepted command unchanged.
REQ-033 Send A5 02 11 then stall TIMEOUT_CYCLES cycles -> state IDLE, o_err_cnt 1; next full frame decodes correctly.
REQ-034 Leading junk 00 FF 5A then valid frame with 0xA5 in address byte -> command decoded with that address, o_err_cnt 0.
REQ-035 Force 260 checksum errors -> o_err_cnt 255; i_rst mid-frame -> all outputs at reset values next cycle.
